// File: rtl/memory_ctrl_mc.sv
// memory_ctrl_mc: round-robin arbiter of NUM_CH single-beat read/write
// requesters onto one memory core port with RD_LAT-cycle read latency.
// Ports: clk, reset (sync, active-high); per-channel cmd_valid/we/addr/wdata
// in, ready/rvalid out, shared rdata; core side ce_mem/we_mem/addr_mem/
// datai_mem out, datao_mem in.
module memory_ctrl_mc #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int NUM_CH = 2,
  parameter int RD_LAT = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        cmd_valid,
  input  logic [NUM_CH-1:0]        we,
  input  logic [NUM_CH*ADDR_W-1:0] addr,
  input  logic [NUM_CH*DATA_W-1:0] wdata,
  output logic [NUM_CH-1:0]        ready,
  output logic [DATA_W-1:0]        rdata,
  output logic [NUM_CH-1:0]        rvalid,
  output logic                     ce_mem,
  output logic                     we_mem,
  output logic [ADDR_W-1:0]        addr_mem,
  output logic [DATA_W-1:0]        datai_mem,
  input  logic [DATA_W-1:0]        datao_mem
);

  localparam int GW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [GW-1:0] LAST_CH = GW'(NUM_CH - 1);
  // WAIT spans RD_LAT-1 cycles: counter runs 0 .. RD_LAT-2
  localparam logic [2:0] WAIT_END = 3'(RD_LAT - 2);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT,
    RETURN
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [GW-1:0]     gnt_q;
  logic [GW-1:0]     last_q;
  logic [GW-1:0]     pick;
  logic [GW-1:0]     idx;
  logic              found;
  logic              cmd_we_q;
  logic [2:0]        cnt_q;
  logic [2:0]        cnt_d;
  logic [NUM_CH-1:0] gnt_oh;

  assign gnt_oh = NUM_CH'(1) << gnt_q;

  // Round-robin: first valid channel after the last grant, wrapping.
  always_comb begin
    pick  = last_q;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = GW'((int'(last_q) + k) % NUM_CH);
      if (!found && cmd_valid[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (found) state_d = ACCESS;
      end
      ACCESS: begin
        if (cmd_we_q) begin
          state_d = IDLE;
        end else if (RD_LAT > 1) begin
          state_d = WAIT;
          cnt_d   = '0;
        end else begin
          state_d = RETURN;
        end
      end
      WAIT: begin
        if (cnt_q == WAIT_END) state_d = RETURN;
        else cnt_d = cnt_q + 3'd1;
      end
      RETURN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ce_mem = (state_q == ACCESS);
    we_mem = ce_mem & cmd_we_q;
    ready  = ce_mem ? gnt_oh : '0;
  end

  // addr_mem/datai_mem double as the latched command, so they hold
  // their last value outside ACCESS.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      last_q    <= LAST_CH;
      gnt_q     <= '0;
      cnt_q     <= '0;
      cmd_we_q  <= 1'b0;
      addr_mem  <= '0;
      datai_mem <= '0;
      rdata     <= '0;
      rvalid    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rvalid  <= '0;
      if (state_q == IDLE && found) begin
        gnt_q     <= pick;
        last_q    <= pick;
        cmd_we_q  <= we[pick];
        addr_mem  <= addr[int'(pick)*ADDR_W +: ADDR_W];
        datai_mem <= wdata[int'(pick)*DATA_W +: DATA_W];
      end
      if (state_q == RETURN) begin
        rdata  <= datao_mem;
        rvalid <= gnt_oh;
      end
    end
  end

endmodule

// File: tb/tb_memory_ctrl_mc.sv
// tb_memory_ctrl_mc: four 4-channel controllers with RD_LAT 1..4, each
// driving its own behavioural memory core model.
module tb_memory_ctrl_mc;

  localparam int ND = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [3:0]  cv  [ND];
  logic [3:0]  wv  [ND];
  logic [31:0] ad  [ND];
  logic [31:0] wd  [ND];
  logic [3:0]  rdy [ND];
  logic [3:0]  rv  [ND];
  logic [7:0]  rd  [ND];
  logic        ce  [ND];
  logic        wem [ND];
  logic [7:0]  am  [ND];
  logic [7:0]  dm  [ND];
  logic [7:0]  dom [ND];

  int checks = 0;
  int failures = 0;

  for (genvar g = 0; g < ND; g++) begin : gd
    logic [7:0] mem  [256];
    logic [7:0] pipe [g+1];

    memory_ctrl_mc #(
      .DATA_W(8), .ADDR_W(8), .NUM_CH(4), .RD_LAT(g + 1)
    ) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cv[g]), .we(wv[g]),
      .addr(ad[g]), .wdata(wd[g]),
      .ready(rdy[g]), .rdata(rd[g]), .rvalid(rv[g]),
      .ce_mem(ce[g]), .we_mem(wem[g]),
      .addr_mem(am[g]), .datai_mem(dm[g]),
      .datao_mem(dom[g])
    );

    // Core: data valid RD_LAT cycles after a read strobe, garbage otherwise
    always @(posedge clk) begin
      if (ce[g] === 1'b1 && wem[g] === 1'b1) mem[am[g]] <= dm[g];
      pipe[0] <= (ce[g] === 1'b1 && wem[g] === 1'b0) ? mem[am[g]] : 8'hEE;
      for (int s = 1; s <= g; s++) pipe[s] <= pipe[s-1];
    end
    assign dom[g] = pipe[g];
  end

  task automatic set_ch(input int d, input int ch, input bit v, input bit w,
                        input logic [7:0] a, input logic [7:0] dat);
    cv[d][ch] = v;
    wv[d][ch] = w;
    ad[d][ch*8 +: 8] = a;
    wd[d][ch*8 +: 8] = dat;
  endtask

  task automatic clear_all();
    for (int d = 0; d < ND; d++) begin
      cv[d] = '0; wv[d] = '0; ad[d] = '0; wd[d] = '0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int d = 0; d < ND; d++) begin
      cv[d] = 4'hF; wv[d] = 4'hF; ad[d] = '0; wd[d] = '0;
    end
    repeat (3) begin
      @(negedge clk);
      for (int d = 0; d < ND; d++) begin
        checks++;
        if ({rdy[d], rv[d], ce[d], wem[d], am[d], dm[d], rd[d]} !== 34'd0) begin
          failures++;
          $display("FAIL reset_outputs dut%0d got %h want 0", d,
                   {rdy[d], rv[d], ce[d], wem[d], am[d], dm[d], rd[d]});
        end
      end
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (rdy[0] !== 4'b0001) begin
      failures++;
      $display("FAIL reset_first_grant got %b want 0001", rdy[0]);
    end
    clear_all();
    @(negedge clk);
  endtask

  task automatic test_write_read();
    set_ch(0, 0, 1, 1, 8'h12, 8'hA5);
    @(negedge clk);
    checks++;
    if ({rdy[0], ce[0], wem[0], am[0], dm[0]} !== {4'b0001, 1'b1, 1'b1, 8'h12, 8'hA5}) begin
      failures++;
      $display("FAIL wr_access got rdy=%b ce=%b we=%b a=%h d=%h want 0001 1 1 12 a5",
               rdy[0], ce[0], wem[0], am[0], dm[0]);
    end
    clear_all();
    @(negedge clk);
    checks++;
    if (ce[0] !== 1'b0 || rdy[0] !== 4'b0) begin
      failures++;
      $display("FAIL wr_idle got ce=%b rdy=%b want 0 0000", ce[0], rdy[0]);
    end
    set_ch(0, 0, 1, 0, 8'h12, 8'h00);
    @(negedge clk);
    checks++;
    if ({rdy[0], ce[0], wem[0], am[0]} !== {4'b0001, 1'b1, 1'b0, 8'h12}) begin
      failures++;
      $display("FAIL rd_access got rdy=%b ce=%b we=%b a=%h want 0001 1 0 12",
               rdy[0], ce[0], wem[0], am[0]);
    end
    clear_all();
    @(negedge clk);
    checks++;
    if (rv[0] !== 4'b0 || ce[0] !== 1'b0) begin
      failures++;
      $display("FAIL rd_return got rv=%b ce=%b want 0000 0", rv[0], ce[0]);
    end
    @(negedge clk);
    checks++;
    if (rv[0] !== 4'b0001 || rd[0] !== 8'hA5) begin
      failures++;
      $display("FAIL rd_data got rv=%b rdata=%h want 0001 a5", rv[0], rd[0]);
    end
    @(negedge clk);
    checks++;
    if (rv[0] !== 4'b0) begin
      failures++;
      $display("FAIL rd_pulse got rv=%b want 0000", rv[0]);
    end
  endtask

  // Channel 0 was granted last, so rotation starts at channel 1.
  task automatic test_round_robin();
    for (int ch = 0; ch < 4; ch++) set_ch(0, ch, 1, 1, 8'(8'h20 + ch), 8'(8'h50 + ch));
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checks++;
      if (rdy[0] !== 4'(1 << ((k + 1) % 4)) || am[0] !== 8'(8'h20 + (k + 1) % 4)) begin
        failures++;
        $display("FAIL rr_grant%0d got rdy=%b a=%h want %b %h", k, rdy[0], am[0],
                 4'(1 << ((k + 1) % 4)), 8'(8'h20 + (k + 1) % 4));
      end
      if (k == 7) clear_all();
      @(negedge clk);
      checks++;
      if (rdy[0] !== 4'b0) begin
        failures++;
        $display("FAIL rr_gap%0d got rdy=%b want 0000", k, rdy[0]);
      end
    end
  endtask

  task automatic test_latency();
    for (int d = 0; d < ND; d++) begin
      int seen;
      int nce;
      set_ch(d, 2, 1, 1, 8'hFF, 8'h3C);
      @(negedge clk);
      checks++;
      if (rdy[d] !== 4'b0100) begin
        failures++;
        $display("FAIL lat%0d_wr got rdy=%b want 0100", d + 1, rdy[d]);
      end
      clear_all();
      @(negedge clk);
      set_ch(d, 1, 1, 0, 8'hFF, 8'h00);
      seen = 0;
      nce = 0;
      for (int t = 1; t <= 12; t++) begin
        @(negedge clk);
        if (ce[d] === 1'b1) nce++;
        if (rdy[d] !== 4'b0) clear_all();
        if (rv[d] !== 4'b0) begin
          seen = t;
          checks++;
          if (rv[d] !== 4'b0010 || rd[d] !== 8'h3C || ce[d] !== 1'b0) begin
            failures++;
            $display("FAIL lat%0d_data got rv=%b rdata=%h ce=%b want 0010 3c 0",
                     d + 1, rv[d], rd[d], ce[d]);
          end
          break;
        end
      end
      checks++;
      if (seen != d + 3) begin
        failures++;
        $display("FAIL lat%0d_cycles got %0d want %0d", d + 1, seen, d + 3);
      end
      checks++;
      if (nce != 1) begin
        failures++;
        $display("FAIL lat%0d_ce got %0d cycles want 1", d + 1, nce);
      end
      clear_all();
    end
  endtask

  task automatic test_cross_raw();
    set_ch(0, 0, 1, 1, 8'h41, 8'h11);
    @(negedge clk);
    checks++;
    if (rdy[0] !== 4'b0001) begin
      failures++;
      $display("FAIL raw_pre got rdy=%b want 0001", rdy[0]);
    end
    set_ch(0, 0, 1, 0, 8'h40, 8'h00);
    set_ch(0, 1, 1, 1, 8'h40, 8'h77);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({rdy[0], wem[0], am[0], dm[0]} !== {4'b0010, 1'b1, 8'h40, 8'h77}) begin
      failures++;
      $display("FAIL raw_wr got rdy=%b we=%b a=%h d=%h want 0010 1 40 77",
               rdy[0], wem[0], am[0], dm[0]);
    end
    set_ch(0, 1, 0, 0, 8'h00, 8'h00);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({rdy[0], wem[0], am[0]} !== {4'b0001, 1'b0, 8'h40}) begin
      failures++;
      $display("FAIL raw_rd got rdy=%b we=%b a=%h want 0001 0 40", rdy[0], wem[0], am[0]);
    end
    clear_all();
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (rv[0] !== 4'b0001 || rd[0] !== 8'h77) begin
      failures++;
      $display("FAIL raw_data got rv=%b rdata=%h want 0001 77", rv[0], rd[0]);
    end
  endtask

  // Channel 1 granted before reset: without restore, channel 2 would win.
  task automatic test_reset_mid_read();
    bit bad;
    set_ch(2, 1, 1, 0, 8'hFF, 8'h00);
    @(negedge clk);
    checks++;
    if (rdy[2] !== 4'b0010 || ce[2] !== 1'b1) begin
      failures++;
      $display("FAIL mid_access got rdy=%b ce=%b want 0010 1", rdy[2], ce[2]);
    end
    clear_all();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (rv[2] !== 4'b0 || rd[2] !== 8'h00 || ce[2] !== 1'b0 || am[2] !== 8'h00) begin
      failures++;
      $display("FAIL mid_reset got rv=%b rdata=%h ce=%b a=%h want 0000 00 0 00",
               rv[2], rd[2], ce[2], am[2]);
    end
    reset = 1'b0;
    bad = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (rv[2] !== 4'b0 || ce[2] !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL mid_abandon got activity after reset want none");
    end
    for (int ch = 0; ch < 4; ch++) set_ch(2, ch, 1, 1, 8'(8'h80 + ch), 8'(ch));
    @(negedge clk);
    checks++;
    if (rdy[2] !== 4'b0001) begin
      failures++;
      $display("FAIL mid_regrant got rdy=%b want 0001", rdy[2]);
    end
    clear_all();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    clear_all();
    test_reset();
    test_write_read();
    test_round_robin();
    test_latency();
    test_cross_raw();
    test_reset_mid_read();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
